// File: rtl/shift_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// shift_pkg: op encodings, FSM states and default widths. Rev 1.0
// ------------------------------------------------------------------
package shift_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_AMT_W  = 5;

  typedef logic [2:0] op_t;

  localparam op_t OP_SLL = 3'b000;
  localparam op_t OP_SRL = 3'b001;
  localparam op_t OP_SRA = 3'b010;
  localparam op_t OP_ROR = 3'b011;
  localparam op_t OP_ROL = 3'b100;
  localparam op_t OP_NOP = 3'b111;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  // Encodings above OP_ROL are all treated as NOP.
  function automatic logic is_shift_op(input op_t op);
    return (op <= OP_ROL);
  endfunction

endpackage
`default_nettype wire

// File: rtl/shift_step.sv
`default_nettype none
// ------------------------------------------------------------------
// shift_step: combinational single-position shift/rotate. Rev 1.0
// ------------------------------------------------------------------
module shift_step
  import shift_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  op_t               op,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  always_comb begin
    dout = din;
    case (op)
      OP_SLL:  dout = {din[DATA_W-2:0], 1'b0};
      OP_SRL:  dout = {1'b0, din[DATA_W-1:1]};
      // MSB is never altered by SRA, so replicating it keeps the original sign.
      OP_SRA:  dout = {din[DATA_W-1], din[DATA_W-1:1]};
      OP_ROR:  dout = {din[0], din[DATA_W-1:1]};
      OP_ROL:  dout = {din[DATA_W-2:0], din[DATA_W-1]};
      default: dout = din;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/shift_unit_seq.sv
`default_nettype none
// ------------------------------------------------------------------
// shift_unit_seq: multi-cycle shifter, one bit position per clock,
// with start/busy/done handshake. Rev 1.0
// ------------------------------------------------------------------
module shift_unit_seq
  import shift_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int AMT_W   = DEF_AMT_W,
  parameter int AMT_LSB = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic              amt_sel,
  input  logic [AMT_W-1:0]  shamt_in,
  input  logic [DATA_W-1:0] amt_reg,
  input  logic [DATA_W-1:0] data_in,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic [AMT_W-1:0]  amt_out
);

  logic [1:0]        state;
  logic [DATA_W-1:0] work;
  logic [DATA_W-1:0] step_out;
  logic [AMT_W-1:0]  cnt;
  logic [AMT_W-1:0]  amt;
  op_t               op_q;
  logic              accept;
  logic              unused_amt_reg;

  // Field is taken as-is: upper bits of amt_reg never extend it.
  assign amt            = amt_sel ? amt_reg[AMT_LSB +: AMT_W] : shamt_in;
  assign unused_amt_reg = ^amt_reg;
  assign accept         = start && (state == ST_IDLE || state == ST_DONE);
  assign busy           = (state == ST_SHIFT);
  assign done           = (state == ST_DONE);

  shift_step #(.DATA_W(DATA_W)) u_step (
    .op   (op_q),
    .din  (work),
    .dout (step_out)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      work    <= '0;
      op_q    <= OP_SLL;
      cnt     <= '0;
      result  <= '0;
      amt_out <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (accept) begin
            work    <= data_in;
            op_q    <= op;
            cnt     <= amt;
            amt_out <= amt;
            if (amt == '0 || !is_shift_op(op)) begin
              state  <= ST_DONE;
              result <= data_in;
            end else begin
              state <= ST_SHIFT;
            end
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_SHIFT: begin
          work <= step_out;
          cnt  <= cnt - AMT_W'(1);
          if (cnt == AMT_W'(1)) begin
            state  <= ST_DONE;
            result <= step_out;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_shift_unit_seq.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_shift_unit_seq: directed self-checking bench, 32- and 16-bit
// instances. Rev 1.0
// ------------------------------------------------------------------
module tb_shift_unit_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b0;

  logic        start = 1'b0;
  logic [2:0]  op = 3'b000;
  logic        amt_sel = 1'b0;
  logic [4:0]  shamt_in = '0;
  logic [31:0] amt_reg = '0;
  logic [31:0] data_in = '0;
  logic        busy, done;
  logic [31:0] result;
  logic [4:0]  amt_out;

  logic        start16 = 1'b0;
  logic [2:0]  op16 = 3'b000;
  logic        sel16 = 1'b0;
  logic [3:0]  sh16 = '0;
  logic [15:0] areg16 = '0;
  logic [15:0] din16 = '0;
  logic        busy16, done16;
  logic [15:0] res16;
  logic [3:0]  amt16;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  shift_unit_seq #(.DATA_W(32), .AMT_W(5), .AMT_LSB(0)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .amt_sel(amt_sel),
    .shamt_in(shamt_in), .amt_reg(amt_reg), .data_in(data_in),
    .busy(busy), .done(done), .result(result), .amt_out(amt_out)
  );

  shift_unit_seq #(.DATA_W(16), .AMT_W(4), .AMT_LSB(0)) dut16 (
    .clk(clk), .reset(reset), .start(start16), .op(op16), .amt_sel(sel16),
    .shamt_in(sh16), .amt_reg(areg16), .data_in(din16),
    .busy(busy16), .done(done16), .result(res16), .amt_out(amt16)
  );

  // Presents one start cycle; returns at the first negedge after acceptance.
  task automatic issue(input logic [2:0] o, input logic sel, input logic [4:0] sh,
                       input logic [31:0] ar, input logic [31:0] d);
    op = o; amt_sel = sel; shamt_in = sh; amt_reg = ar; data_in = d; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int n, output int nb);
    n = 0; nb = 0;
    while (!done && n < 100) begin
      if (busy) nb++;
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b expected 0", done); end
    tests++; if (result !== 32'h0) begin fails++; $display("FAIL reset_result: got %h expected 00000000", result); end
    tests++; if (amt_out !== 5'd0) begin fails++; $display("FAIL reset_amt_out: got %0d expected 0", amt_out); end
    tests++; if (res16 !== 16'h0 || busy16 !== 1'b0) begin fails++; $display("FAIL reset_dut16: got %h/%b expected 0000/0", res16, busy16); end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_op;
    int n, nb;
    bit saw_done;
    issue(3'b000, 1'b0, 5'd1, 32'h0, 32'h0000_0001);
    wait_done(n, nb);
    tests++; if (result !== 32'h0000_0002) begin fails++; $display("FAIL pre_reset_sll1: got %h expected 00000002", result); end
    @(negedge clk);
    issue(3'b000, 1'b0, 5'd20, 32'h0, 32'h0000_0001);
    repeat (4) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL midop_busy: got %b expected 0", busy); end
    tests++; if (result !== 32'h0) begin fails++; $display("FAIL midop_result: got %h expected 00000000", result); end
    tests++; if (amt_out !== 5'd0) begin fails++; $display("FAIL midop_amt_out: got %0d expected 0", amt_out); end
    @(negedge clk);
    reset = 1'b1;
    saw_done = 1'b0;
    repeat (25) begin
      @(negedge clk);
      if (done || busy) saw_done = 1'b1;
    end
    tests++; if (saw_done !== 1'b0) begin fails++; $display("FAIL midop_no_done: got %b expected 0", saw_done); end
    issue(3'b000, 1'b0, 5'd1, 32'h0, 32'h0000_0001);
    wait_done(n, nb);
    tests++; if (result !== 32'h0000_0002) begin fails++; $display("FAIL post_reset_sll1: got %h expected 00000002", result); end
    @(negedge clk);
  endtask

  task automatic test_imm_amount;
    int n, nb;
    issue(3'b010, 1'b0, 5'd4, 32'hFFFF_FFFF, 32'h8000_0010);
    wait_done(n, nb);
    tests++; if (result !== 32'hF800_0001) begin fails++; $display("FAIL sra4_result: got %h expected f8000001", result); end
    tests++; if (nb !== 4) begin fails++; $display("FAIL sra4_busy_cycles: got %0d expected 4", nb); end
    tests++; if (n !== 4) begin fails++; $display("FAIL sra4_done_latency: got %0d expected 4", n); end
    tests++; if (amt_out !== 5'd4) begin fails++; $display("FAIL sra4_amt_out: got %0d expected 4", amt_out); end
    @(negedge clk);
    tests++; if (done !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL sra4_done_pulse: got done=%b busy=%b expected 0/0", done, busy); end
    tests++; if (result !== 32'hF800_0001) begin fails++; $display("FAIL sra4_result_held: got %h expected f8000001", result); end
  endtask

  task automatic test_reg_field;
    int n, nb;
    issue(3'b001, 1'b1, 5'd7, 32'hFFFF_FFE3, 32'h8000_0000);
    wait_done(n, nb);
    tests++; if (result !== 32'h1000_0000) begin fails++; $display("FAIL regamt_result: got %h expected 10000000", result); end
    tests++; if (amt_out !== 5'd3) begin fails++; $display("FAIL regamt_amt_out: got %0d expected 3", amt_out); end
    tests++; if (nb !== 3) begin fails++; $display("FAIL regamt_busy_cycles: got %0d expected 3", nb); end
    @(negedge clk);
  endtask

  task automatic test_zero_nop;
    int n, nb;
    issue(3'b100, 1'b0, 5'd0, 32'h0, 32'hDEAD_BEEF);
    tests++; if (done !== 1'b1) begin fails++; $display("FAIL zero_done_next: got %b expected 1", done); end
    wait_done(n, nb);
    tests++; if (result !== 32'hDEAD_BEEF) begin fails++; $display("FAIL zero_result: got %h expected deadbeef", result); end
    tests++; if (nb !== 0) begin fails++; $display("FAIL zero_busy: got %0d expected 0", nb); end
    @(negedge clk);
    issue(3'b111, 1'b0, 5'd5, 32'h0, 32'h1234_5678);
    tests++; if (done !== 1'b1 || busy !== 1'b0) begin fails++; $display("FAIL nop_done_next: got done=%b busy=%b expected 1/0", done, busy); end
    tests++; if (result !== 32'h1234_5678) begin fails++; $display("FAIL nop_result: got %h expected 12345678", result); end
    tests++; if (amt_out !== 5'd5) begin fails++; $display("FAIL nop_amt_out: got %0d expected 5", amt_out); end
    @(negedge clk);
  endtask

  task automatic test_rotate_max;
    int n, nb;
    logic [2:0]  ops  [4] = '{3'b011, 3'b100, 3'b010, 3'b000};
    logic [31:0] dins [4] = '{32'h0000_0001, 32'h8000_0000, 32'h8000_0000, 32'h0000_0003};
    logic [31:0] exps [4] = '{32'h0000_0002, 32'h4000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
    for (int i = 0; i < 4; i++) begin
      issue(ops[i], 1'b0, 5'd31, 32'h0, dins[i]);
      wait_done(n, nb);
      tests++;
      if (result !== exps[i] || n !== 31) begin
        fails++;
        $display("FAIL max31_vec%0d: got %h after %0d cycles expected %h after 31", i, result, n, exps[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_start_while_busy;
    int n;
    issue(3'b000, 1'b0, 5'd8, 32'h0, 32'h0000_0001);
    n = 0;
    while (!done && n < 100) begin
      if (n == 2) begin
        start = 1'b1; op = 3'b001; data_in = 32'hFFFF_FFFF; shamt_in = 5'd1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    tests++; if (result !== 32'h0000_0100 || n !== 8) begin fails++; $display("FAIL busy_start_ignored: got %h after %0d expected 00000100 after 8", result, n); end
    tests++; if (amt_out !== 5'd8) begin fails++; $display("FAIL busy_start_amt_out: got %0d expected 8", amt_out); end
    @(negedge clk);
    tests++; if (done !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL busy_start_no_queue: got done=%b busy=%b expected 0/0", done, busy); end
  endtask

  task automatic test_back_to_back;
    int n, nb;
    issue(3'b000, 1'b0, 5'd3, 32'h0, 32'h0000_0001);
    wait_done(n, nb);
    tests++; if (result !== 32'h0000_0008) begin fails++; $display("FAIL b2b_first: got %h expected 00000008", result); end
    issue(3'b001, 1'b0, 5'd2, 32'h0, 32'h0000_00F0);
    tests++; if (busy !== 1'b1 || done !== 1'b0) begin fails++; $display("FAIL b2b_accept: got busy=%b done=%b expected 1/0", busy, done); end
    tests++; if (result !== 32'h0000_0008) begin fails++; $display("FAIL b2b_result_held: got %h expected 00000008", result); end
    wait_done(n, nb);
    tests++; if (result !== 32'h0000_003C || n !== 2) begin fails++; $display("FAIL b2b_second: got %h after %0d expected 0000003c after 2", result, n); end
    issue(3'b000, 1'b0, 5'd0, 32'h0, 32'h0000_0055);
    tests++; if (done !== 1'b1 || result !== 32'h0000_0055) begin fails++; $display("FAIL b2b_zero: got done=%b result=%h expected 1/00000055", done, result); end
    @(negedge clk);
  endtask

  task automatic test_width16;
    int n;
    logic [2:0]  ops  [2] = '{3'b000, 3'b011};
    logic [15:0] exps [2] = '{16'h8000, 16'h0002};
    for (int i = 0; i < 2; i++) begin
      op16 = ops[i]; sel16 = 1'b0; sh16 = 4'd15; din16 = 16'h0001; start16 = 1'b1;
      @(negedge clk);
      start16 = 1'b0;
      n = 0;
      while (!done16 && n < 100) begin
        @(negedge clk);
        n++;
      end
      tests++;
      if (res16 !== exps[i] || n !== 15 || amt16 !== 4'd15) begin
        fails++;
        $display("FAIL w16_vec%0d: got %h after %0d amt %0d expected %h after 15 amt 15", i, res16, n, amt16, exps[i]);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset;
    test_reset_mid_op;
    test_imm_amount;
    test_reg_field;
    test_zero_nop;
    test_rotate_max;
    test_start_while_busy;
    test_back_to_back;
    test_width16;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/shift_unit_seq.md
Name: shift_unit_seq

Overview:
- Parametrised multi-cycle shifter for the multi-cycle datapath. Replaces fixed 5-bit shift-amount extraction plus the combinational shift path.
- Selects the shift amount from an instruction field or from a bit-field of a register operand.
- Performs logical, arithmetic or rotate shifts at one bit position per clock.
- Exposes a start/busy/done handshake so the control FSM can hold its state until the result is valid.

Parameters:
- DATA_W, 32, operand and result width.
- AMT_W, 5, shift-amount width; must equal clog2(DATA_W).
- AMT_LSB, 0, LSB position of the shift-amount field inside amt_reg; field is amt_reg[AMT_LSB +: AMT_W].

Ports:
- clk, input, 1, system clock; all state updates on rising edge.
- reset, input, 1, asynchronous active-low reset (0 = reset).
- start, input, 1, single-cycle request; sampled only in IDLE or DONE.
- op, input, 3, 000 SLL, 001 SRL, 010 SRA, 011 ROR, 100 ROL, others NOP.
- amt_sel, input, 1, 0 = shamt_in, 1 = field of amt_reg.
- shamt_in, input, AMT_W, immediate shift amount (instruction shamt field).
- amt_reg, input, DATA_W, register operand supplying the variable amount.
- data_in, input, DATA_W, value to shift.
- busy, output, 1, high while in SHIFT.
- done, output, 1, one-cycle pulse when result is valid.
- result, output, DATA_W, shifted value; held until next accepted start.
- amt_out, output, AMT_W, amount latched for the current or last operation (debug).

Behaviour:
- Reset (reset = 0, asynchronous): state = IDLE, busy = 0, done = 0, result = 0, amt_out = 0, internal counter = 0.
  - Reset during SHIFT aborts the operation. No done is produced.
- States: IDLE, SHIFT, DONE.
- IDLE, start = 1:
  - Latch data_in into the working register, op, and amount into the counter and amt_out.
  - Amount = amt_sel ? amt_reg[AMT_LSB +: AMT_W] : shamt_in, taken unsigned with no sign extension.
  - Amount 0 or op NOP: go to DONE; result = data_in.
  - Otherwise: go to SHIFT, busy = 1.
- SHIFT, each cycle: working register shifts one position per the latched op, counter decrements.
  - SLL: insert 0 at LSB.
  - SRL: insert 0 at MSB.
  - SRA: replicate the original MSB.
  - ROR/ROL: wrap the bit around.
  - When the counter reaches 1, the final shift occurs and the next state is DONE.
- DONE (one cycle): done = 1, busy = 0, result = working register.
  - start = 1: accepted exactly as in IDLE, giving back-to-back operation.
  - start = 0: go to IDLE.
- Latency from the start cycle to the done cycle:
  - max(N, 1) cycles for amount N, so amount 0 gives done in the cycle after start.
  - Maximum DATA_W-1 cycles.
- start while busy: ignored; no queueing. Input changes during SHIFT have no effect.
- Width rules:
  - The amount can never reach DATA_W, so no saturation is needed.
  - SRA of a negative value by DATA_W-1 gives all ones.
  - Rotates by N equal the combinational rotate by N.
- result changes only on entry to DONE or on reset. It is stable in IDLE and throughout SHIFT.

Decomposition:
- Shared package (shift_pkg): op encodings (OP_SLL..OP_ROL, OP_NOP), state enum (ST_IDLE, ST_SHIFT, ST_DONE), default DATA_W / AMT_W constants.
- One natural sub-module: shift_step, a combinational single-position shift/rotate of DATA_W bits selected by op, instantiated once in the datapath.
- Amount mux, counter and FSM stay in shift_unit_seq.

Test Plan:
1. Reset mid-op:
   - SLL 0x00000001 by 20, assert reset (low) at cycle 5.
   - Expect busy = 0, done never pulses, result = 0.
   - Release reset, SLL by 1: result 0x00000002.
2. Immediate amount:
   - op = SRA, amt_sel = 0, shamt_in = 4, data_in = 0x80000010.
   - Expect done 4 cycles after start, result 0xF8000001.
   - busy high for exactly 4 cycles.
3. Register field amount:
   - AMT_LSB = 0, amt_sel = 1, amt_reg = 0xFFFFFFE3 (field = 3), op = SRL, data_in = 0x80000000.
   - Expect result 0x10000000 and amt_out = 3 (no sign extension of the field).
4. Zero amount and NOP:
   - op = ROL, shamt_in = 0, data_in = 0xDEADBEEF: done next cycle, result 0xDEADBEEF.
   - op = 111: same response.
5. Rotates and max amount:
   - ROR 0x00000001 by 31 → 0x00000002.
   - ROL 0x80000000 by 31 → 0x40000000.
   - SRA 0x80000000 by 31 → 0xFFFFFFFF.
6. Handshake edges:
   - start during SHIFT is ignored.
   - start asserted in the DONE cycle: new op accepted, busy next cycle, previous result held until the new done.
   - Repeat with DATA_W = 16, AMT_W = 4: SLL 0x0001 by 15 → 0x8000.
